mdu_ctrl: RTL
=============

// Module: mdu_ctrl
// PURPOSE
//   E-stage multiply/divide unit with its sequencer. Latches operands and MDUType from CU,
//   computes the result, and holds it for a fixed latency before committing it to HI/LO.
//   Owns HI/LO and drives MDUO for mfhi/mflo.
//   Raises the D-stage stall for any mf/mt/md instruction that arrives while an operation
//   is starting or in flight.
// PARAMETERS
//   MULT_LAT  5   busy cycles for mult/multu (>=1)
//   DIV_LAT   10  busy cycles for div/divu (>=1)
//   CNT_W     4   counter width; must hold max(MULT_LAT,DIV_LAT)
// PORTS
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-low; 0 clears all state immediately
//   E_MDUType  in   5   `MDUType_* code of E-stage instr; 5'd31 = none
//   E_A        in   32  forwarded rs value
//   E_B        in   32  forwarded rt value
//   D_use_mdu  in   1   D-stage instr type is `md, `mf or `mt
//   start      out  1   comb: E_MDUType is mult/multu/div/divu and busy==0
//   busy       out  1   registered-state derived: cnt!=0
//   stall      out  1   comb: D_use_mdu & (start | busy)
//   HI         out  32  HI register
//   LO         out  32  LO register
//   MDUO       out  32  comb: HI if E_MDUType==`MDUType_mfhi, LO if `MDUType_mflo, else 0
//   cancel     in   1   only with MDU_CANCEL_EN; abort in-flight op
// BEHAVIOUR
//   Reset (async, reset==0): HI=0, LO=0, cnt=0, tmp_hi=tmp_lo=0.
//     Outputs: busy=0, start=0, stall=0.
//   FSM: state is implicit in cnt. IDLE = cnt==0; BUSY = cnt!=0.
//   IDLE, edge with start:
//     - cnt <= MULT_LAT (mult/multu) or DIV_LAT (div/divu).
//     - {tmp_hi,tmp_lo} <= result computed from E_A/E_B sampled at that edge.
//   BUSY, each edge:
//     - cnt <= cnt-1.
//     - On the edge where cnt==1: HI<=tmp_hi, LO<=tmp_lo; unit returns to IDLE.
//   Timing:
//     - busy is high for exactly LAT cycles after the start cycle.
//     - The new HI/LO are visible in the cycle after busy falls.
//   Arithmetic:
//     - mult: signed 32x32->64, {HI,LO}.
//     - multu: unsigned 32x32->64, {HI,LO}.
//     - div/divu: LO=quotient, HI=remainder; signed quotient truncates toward zero;
//       remainder takes the sign of the dividend.
//     - div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//     - Divisor 0 (div/divu): full DIV_LAT busy period runs; HI/LO are NOT updated.
//   mthi/mtlo:
//     - In IDLE: HI/LO <= E_A at the edge; no busy.
//     - While busy: ignored. This cannot legally occur because stall holds it in D.
//   mf/mt/md arriving while busy or start is high: stall stays asserted until busy==0.
//   md in E while busy: ignored (start=0). Bench flags it as a protocol violation.
//   Simultaneous commit edge (cnt==1) and D_use_mdu:
//     - stall is still 1 that cycle.
//     - The D instr enters E the following cycle and sees the new HI/LO.
//   Reset mid-operation: abort; HI/LO return to 0; no commit.
// CONFIGURATION
//   MDU_CANCEL_EN defined:
//     - The cancel port exists.
//     - cancel==1 at an edge forces cnt<=0 and discards tmp_hi/tmp_lo; HI/LO are unchanged.
//     - cancel suppresses start and mt writes in the same cycle.
//     - Used by the exception-flush path.
//   MDU_CANCEL_EN undefined: no cancel port; every started op always runs to commit.
// TESTING
//   1. Reset low mid-run: assert reset=0 while cnt!=0
//      -> HI=LO=0, busy=0 immediately, before any clock edge.
//   2. mult A=0xFFFFFFFE, B=3 -> busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//   3. divu A=7, B=2 -> busy high for 10 cycles; then LO=3, HI=1.
//      div A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//   4. div by zero, with HI=0x11, LO=0x22 beforehand -> busy high for 10 cycles; HI/LO stay 0x11/0x22.
//   5. mult issued, then mflo in D on the next cycle -> stall=1 for 5 cycles;
//      MDUO returns the new LO once mflo reaches E.
//      mthi 0xABCD while idle -> HI=0xABCD the next cycle, stall=0.
//   6. (MDU_CANCEL_EN) div started, cancel at cycle 3
//      -> busy=0 the next cycle; HI/LO unchanged; a following mult starts normally.

Source files
------------

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide unit: latches the operation at start, holds the result for a
// fixed latency, then commits it to HI/LO. Optional abort port under `MDU_CANCEL_EN`.
module mdu_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  E_MDUType,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_use_mdu,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUO
);

  // MDUType encodings; 5'd31 means no MDU instruction in E
  localparam logic [4:0] MDU_MULT  = 5'd0;
  localparam logic [4:0] MDU_MULTU = 5'd1;
  localparam logic [4:0] MDU_DIV   = 5'd2;
  localparam logic [4:0] MDU_DIVU  = 5'd3;
  localparam logic [4:0] MDU_MFHI  = 5'd4;
  localparam logic [4:0] MDU_MFLO  = 5'd5;
  localparam logic [4:0] MDU_MTHI  = 5'd6;
  localparam logic [4:0] MDU_MTLO  = 5'd7;

  localparam int unsigned DW = 32;

  logic [CNT_W-1:0] cnt_q,    cnt_nxt;
  logic [DW-1:0]    tmp_hi_q, tmp_hi_nxt;
  logic [DW-1:0]    tmp_lo_q, tmp_lo_nxt;
  logic             skip_q,   skip_nxt;
  logic [DW-1:0]    hi_q,     hi_nxt;
  logic [DW-1:0]    lo_q,     lo_nxt;

  logic             cancel_c;
  logic             is_mul_c;
  logic             is_div_c;
  logic [DW-1:0]    a_abs_c;
  logic [DW-1:0]    b_abs_c;
  logic [DW-1:0]    uq_c;
  logic [DW-1:0]    ur_c;
  logic [2*DW-1:0]  res_c;

`ifdef MDU_CANCEL_EN
  assign cancel_c = cancel;
`else
  assign cancel_c = 1'b0;
`endif

  assign is_mul_c = (E_MDUType == MDU_MULT) || (E_MDUType == MDU_MULTU);
  assign is_div_c = (E_MDUType == MDU_DIV)  || (E_MDUType == MDU_DIVU);

  assign busy  = (cnt_q != '0);
  assign start = (is_mul_c || is_div_c) && !busy && !cancel_c;
  assign stall = D_use_mdu && (start || busy);
  assign HI    = hi_q;
  assign LO    = lo_q;

  // Move-from read port; zero for anything other than mfhi/mflo
  always_comb begin
    MDUO = '0;
    if (E_MDUType == MDU_MFHI) MDUO = hi_q;
    else if (E_MDUType == MDU_MFLO) MDUO = lo_q;
  end

  // Signed divide runs on magnitudes so the quotient truncates toward zero and the
  // remainder follows the dividend; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    a_abs_c = E_A[DW-1] ? (DW'(0) - E_A) : E_A;
    b_abs_c = E_B[DW-1] ? (DW'(0) - E_B) : E_B;
    uq_c    = a_abs_c / b_abs_c;
    ur_c    = a_abs_c % b_abs_c;
    case (E_MDUType)
      MDU_MULT:  res_c = {{DW{E_A[DW-1]}}, E_A} * {{DW{E_B[DW-1]}}, E_B};
      MDU_MULTU: res_c = {{DW{1'b0}}, E_A} * {{DW{1'b0}}, E_B};
      MDU_DIV:   res_c = {(E_A[DW-1] ? (DW'(0) - ur_c) : ur_c),
                          ((E_A[DW-1] ^ E_B[DW-1]) ? (DW'(0) - uq_c) : uq_c)};
      MDU_DIVU:  res_c = {E_A % E_B, E_A / E_B};
      default:   res_c = '0;
    endcase
  end

  // Sequencer: IDLE is cnt==0, BUSY counts down and commits on the cnt==1 edge
  always_comb begin
    cnt_nxt    = cnt_q;
    tmp_hi_nxt = tmp_hi_q;
    tmp_lo_nxt = tmp_lo_q;
    skip_nxt   = skip_q;
    hi_nxt     = hi_q;
    lo_nxt     = lo_q;
    if (cancel_c) begin
      cnt_nxt    = '0;
      tmp_hi_nxt = '0;
      tmp_lo_nxt = '0;
      skip_nxt   = 1'b0;
    end else if (busy) begin
      cnt_nxt = cnt_q - CNT_W'(1);
      if ((cnt_q == CNT_W'(1)) && !skip_q) begin
        hi_nxt = tmp_hi_q;
        lo_nxt = tmp_lo_q;
      end
    end else if (start) begin
      cnt_nxt    = is_mul_c ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
      tmp_hi_nxt = res_c[2*DW-1:DW];
      tmp_lo_nxt = res_c[DW-1:0];
      skip_nxt   = is_div_c && (E_B == '0);
    end else if (E_MDUType == MDU_MTHI) begin
      hi_nxt = E_A;
    end else if (E_MDUType == MDU_MTLO) begin
      lo_nxt = E_A;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      skip_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      cnt_q    <= cnt_nxt;
      tmp_hi_q <= tmp_hi_nxt;
      tmp_lo_q <= tmp_lo_nxt;
      skip_q   <= skip_nxt;
      hi_q     <= hi_nxt;
      lo_q     <= lo_nxt;
    end
  end

endmodule
